// File: rtl/tank_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tank_update_scheduler
// Description : Buffers CPU register writes to tank sprite controllers and
//               replays them one per cycle during vertical blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module tank_update_scheduler #(
    parameter int NUM_TANKS = 4,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [1:0]           req_tank_i,
    input  logic [1:0]           req_addr_i,
    input  logic [31:0]          req_data_i,
    input  logic                 vblank_i,
    output logic [NUM_TANKS-1:0] MW_o,
    output logic [1:0]           address_o,
    output logic [31:0]          data_o,
    output logic [3:0]           pending_o,
    output logic                 frame_done_o,
    output logic                 drop_o
);

    localparam int         PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] c_depth     = 4'(DEPTH);
    localparam logic [2:0] c_num_tanks = 3'(NUM_TANKS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_tank_mem [DEPTH];
    logic [1:0]       r_addr_mem [DEPTH];
    logic [31:0]      r_data_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [3:0]       r_count;

    logic                 w_accept;
    logic                 w_legal;
    logic                 w_push;
    logic                 w_pop;
    logic [3:0]           w_count_next;
    logic [NUM_TANKS-1:0] w_strobe;

    // Readiness looks only at the stored occupancy, so a full FIFO stays
    // closed even on a cycle where an entry is popped.
    assign req_ready_o  = (r_count < c_depth);
    assign w_accept     = req_valid_i && req_ready_o;
    assign w_legal      = (req_addr_i != 2'b11) && ({1'b0, req_tank_i} < c_num_tanks);
    assign w_push       = w_accept && w_legal;
    // Every edge that sees blanking with something queued drains one entry.
    assign w_pop        = (r_state != S_IDLE) && vblank_i;
    assign w_count_next = r_count + {3'b000, w_push} - {3'b000, w_pop};
    assign pending_o    = r_count;

    always_comb begin
        w_strobe = '0;
        for (int k = 0; k < NUM_TANKS; k++) begin
            w_strobe[k] = (r_tank_mem[r_rd_ptr] == 2'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tank_mem[r_wr_ptr] <= req_tank_i;
            r_addr_mem[r_wr_ptr] <= req_addr_i;
            r_data_mem[r_wr_ptr] <= req_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            MW_o         <= '0;
            address_o    <= '0;
            data_o       <= '0;
            frame_done_o <= 1'b0;
            drop_o       <= 1'b0;
        end else begin
            drop_o       <= w_accept && !w_legal;
            frame_done_o <= w_pop && (w_count_next == 4'd0);
            r_count      <= w_count_next;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                MW_o      <= w_strobe;
                address_o <= r_addr_mem[r_rd_ptr];
                data_o    <= r_data_mem[r_rd_ptr];
            end else begin
                MW_o      <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_push) begin
                        r_state <= vblank_i ? S_ISSUE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (vblank_i) begin
                        r_state <= (w_count_next == 4'd0) ? S_IDLE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_count_next == 4'd0) begin
                        r_state <= S_IDLE;
                    end else if (!vblank_i) begin
                        r_state <= S_WAIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tank_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_tank_update_scheduler
// Description : Self-checking bench for tank_update_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tank_update_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_tank = 2'd0;
    logic [1:0]  req_addr = 2'd0;
    logic [31:0] req_data = 32'd0;
    logic        vblank = 1'b0;

    logic        req_ready;
    logic [3:0]  mw;
    logic [1:0]  address;
    logic [31:0] data;
    logic [3:0]  pending;
    logic        frame_done;
    logic        drop;

    logic        req_ready3;
    logic [2:0]  mw3;
    logic [1:0]  address3;
    logic [31:0] data3;
    logic [3:0]  pending3;
    logic        frame_done3;
    logic        drop3;

    int errors  = 0;
    int checks  = 0;
    int strobes = 0;
    int s0;

    typedef struct packed {
        logic [1:0]  tank;
        logic [1:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q [$];

    typedef struct {
        logic [1:0]  tank;
        logic [1:0]  addr;
        logic [31:0] data;
        logic        drop;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    tank_update_scheduler #(.NUM_TANKS(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_tank_i(req_tank), .req_addr_i(req_addr), .req_data_i(req_data),
        .vblank_i(vblank),
        .MW_o(mw), .address_o(address), .data_o(data),
        .pending_o(pending), .frame_done_o(frame_done), .drop_o(drop)
    );

    tank_update_scheduler #(.NUM_TANKS(3), .DEPTH(4)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready3),
        .req_tank_i(req_tank), .req_addr_i(req_addr), .req_data_i(req_data),
        .vblank_i(vblank),
        .MW_o(mw3), .address_o(address3), .data_o(data3),
        .pending_o(pending3), .frame_done_o(frame_done3), .drop_o(drop3)
    );

    function automatic logic [3:0] oh(input logic [1:0] t);
        logic [3:0] one;
        one = 4'b0001;
        return one << t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs; the scoreboard learns of accepted legal writes.
    task automatic step(input logic v, input logic [1:0] t, input logic [1:0] a,
                        input logic [31:0] d, input logic vb, input logic r);
        rst       = r;
        req_valid = v;
        req_tank  = t;
        req_addr  = a;
        req_data  = d;
        vblank    = vb;
        if (r) exp_q.delete();
        #1;
        if (!r && v && req_ready && (a != 2'b11)) exp_q.push_back('{t, a, d});
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mw !== 4'b0000) begin
            strobes++;
            if (exp_q.size() == 0) begin
                chk("strobe_unexpected", {28'd0, mw}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_mw", {28'd0, mw}, {28'd0, oh(e.tank)});
                chk("strobe_addr", {30'd0, address}, {30'd0, e.addr});
                chk("strobe_data", data, e.data);
            end
        end
    end

    initial begin
        vecs[0] = '{2'd0, 2'd0, 32'h0000_0011, 1'b0};
        vecs[1] = '{2'd1, 2'd1, 32'h0000_0022, 1'b0};
        vecs[2] = '{2'd2, 2'd2, 32'h0000_0033, 1'b0};
        vecs[3] = '{2'd3, 2'd2, 32'hCAFE_0044, 1'b0};
        vecs[4] = '{2'd2, 2'd3, 32'h0000_0055, 1'b1};
        vecs[5] = '{2'd0, 2'd3, 32'h0000_0066, 1'b1};
        vecs[6] = '{2'd3, 2'd1, 32'hFFFF_FFFF, 1'b0};
        vecs[7] = '{2'd1, 2'd0, 32'h1234_5678, 1'b0};

        @(negedge clk);
        #1;

        // Reset wins over a simultaneous handshake.
        step(1'b1, 2'd1, 2'd0, 32'hDEAD_BEEF, 1'b1, 1'b1);
        chk("rst_pending", {28'd0, pending}, 32'd0);
        chk("rst_mw", {28'd0, mw}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_addr", {30'd0, address}, 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_drop", {31'd0, drop}, 32'd0);
        step(1'b0, 2'd0, 2'd0, 32'd0, 1'b1, 1'b0);
        chk("rst_prio_pending", {28'd0, pending}, 32'd0);
        chk("rst_prio_mw", {28'd0, mw}, 32'd0);

        // Single write held off until blanking.
        step(1'b1, 2'd1, 2'd0, 32'h64, 1'b0, 1'b0);
        chk("single_pending", {28'd0, pending}, 32'd1);
        chk("single_mw_wait", {28'd0, mw}, 32'd0);
        step(1'b0, 2'd0, 2'd0, 32'd0, 1'b0, 1'b0);
        chk("single_mw_novb", {28'd0, mw}, 32'd0);
        step(1'b0, 2'd0, 2'd0, 32'd0, 1'b1, 1'b0);
        chk("single_mw", {28'd0, mw}, 32'b0010);
        chk("single_addr", {30'd0, address}, 32'd0);
        chk("single_data", data, 32'h64);
        chk("single_frame_done", {31'd0, frame_done}, 32'd1);
        chk("single_pending_end", {28'd0, pending}, 32'd0);
        step(1'b0, 2'd0, 2'd0, 32'd0, 1'b1, 1'b0);
        chk("single_mw_after", {28'd0, mw}, 32'd0);
        chk("single_fd_after", {31'd0, frame_done}, 32'd0);
        chk("single_data_hold", data, 32'h64);

        // Table of single requests issued inside blanking.
        for (int i = 0; i < 8; i++) begin
            s0 = strobes;
            step(1'b1, vecs[i].tank, vecs[i].addr, vecs[i].data, 1'b1, 1'b0);
            chk("vec_drop", {31'd0, drop}, {31'd0, vecs[i].drop});
            chk("vec_pending", {28'd0, pending}, vecs[i].drop ? 32'd0 : 32'd1);
            step(1'b0, 2'd0, 2'd0, 32'd0, 1'b1, 1'b0);
            chk("vec_mw", {28'd0, mw}, vecs[i].drop ? 32'd0 : {28'd0, oh(vecs[i].tank)});
            chk("vec_frame_done", {31'd0, frame_done}, {31'd0, !vecs[i].drop});
            step(1'b0, 2'd0, 2'd0, 32'd0, 1'b1, 1'b0);
            chk("vec_strobes", 32'(strobes - s0), vecs[i].drop ? 32'd0 : 32'd1);
        end

        // Fill past capacity outside blanking, then drain.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 2'(k), 2'(k % 3), 32'hA0 + 32'(k), 1'b0, 1'b0);
            chk("full_pending", {28'd0, pending}, 32'(k + 1));
        end
        chk("full_ready", {31'd0, req_ready}, 32'd0);
        step(1'b1, 2'd1, 2'd0, 32'hBAD, 1'b0, 1'b0);
        chk("full_pending_5th", {28'd0, pending}, 32'd4);
        s0 = strobes;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 2'd0, 2'd0, 32'd0, 1'b1, 1'b0);
            chk("full_drain_mw", {28'd0, mw}, {28'd0, oh(2'(k))});
        end
        chk("full_frame_done", {31'd0, frame_done}, 32'd1);
        chk("full_pending_end", {28'd0, pending}, 32'd0);
        step(1'b0, 2'd0, 2'd0, 32'd0, 1'b0, 1'b0);
        chk("full_strobes", 32'(strobes - s0), 32'd4);
        step(1'b0, 2'd0, 2'd0, 32'd0, 1'b1, 1'b0);

        // Illegal targets are accepted and discarded.
        step(1'b1, 2'd0, 2'd3, 32'h77, 1'b1, 1'b0);
        chk("drop_addr11", {31'd0, drop}, 32'd1);
        chk("drop_addr11_pending", {28'd0, pending}, 32'd0);
        step(1'b1, 2'd3, 2'd0, 32'h33, 1'b1, 1'b0);
        chk("drop_pulse_end", {31'd0, drop}, 32'd0);
        chk("drop_tank3_n3", {31'd0, drop3}, 32'd1);
        chk("drop_tank3_n3_pending", {28'd0, pending3}, 32'd0);
        chk("tank3_n4_pending", {28'd0, pending}, 32'd1);
        step(1'b0, 2'd0, 2'd0, 32'd0, 1'b1, 1'b0);
        chk("tank3_n4_mw", {28'd0, mw}, 32'b1000);
        chk("tank3_n3_mw", {29'd0, mw3}, 32'd0);
        step(1'b0, 2'd0, 2'd0, 32'd0, 1'b1, 1'b0);

        // Blanking ends with entries still queued.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 2'(3 - k), 2'd1, 32'hC0 + 32'(k), 1'b0, 1'b0);
        end
        s0 = strobes;
        step(1'b0, 2'd0, 2'd0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 2'd0, 2'd0, 32'd0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 2'd0, 2'd0, 32'd0, 1'b0, 1'b0);
        chk("split_strobes", 32'(strobes - s0), 32'd2);
        chk("split_pending", {28'd0, pending}, 32'd2);
        step(1'b0, 2'd0, 2'd0, 32'd0, 1'b1, 1'b0);
        chk("split_fd_early", {31'd0, frame_done}, 32'd0);
        step(1'b0, 2'd0, 2'd0, 32'd0, 1'b1, 1'b0);
        chk("split_frame_done", {31'd0, frame_done}, 32'd1);
        chk("split_strobes_all", 32'(strobes - s0), 32'd4);

        // Streaming: push every cycle inside blanking.
        s0 = strobes;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 2'(k % 4), 2'(k % 3), 32'hD0 + 32'(k), 1'b1, 1'b0);
            chk("stream_pending", {28'd0, pending}, 32'd1);
            chk("stream_fd", {31'd0, frame_done}, 32'd0);
        end
        step(1'b0, 2'd0, 2'd0, 32'd0, 1'b1, 1'b0);
        chk("stream_frame_done", {31'd0, frame_done}, 32'd1);
        step(1'b0, 2'd0, 2'd0, 32'd0, 1'b1, 1'b0);
        chk("stream_strobes", 32'(strobes - s0), 32'd6);

        // Reset while issuing discards the remainder.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 2'(k), 2'd2, 32'hE0 + 32'(k), 1'b0, 1'b0);
        end
        step(1'b0, 2'd0, 2'd0, 32'd0, 1'b1, 1'b0);
        chk("rstmid_pending_pre", {28'd0, pending}, 32'd3);
        step(1'b0, 2'd0, 2'd0, 32'd0, 1'b1, 1'b1);
        chk("rstmid_mw", {28'd0, mw}, 32'd0);
        chk("rstmid_pending", {28'd0, pending}, 32'd0);
        chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
        s0 = strobes;
        for (int k = 0; k < 4; k++) step(1'b0, 2'd0, 2'd0, 32'd0, 1'b1, 1'b0);
        chk("rstmid_strobes", 32'(strobes - s0), 32'd0);
        chk("rstmid_fd", {31'd0, frame_done}, 32'd0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
